// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port integer register file.
// No logic: typedefs, default sizes and the index-width helper only.
// Imported by the interface, the scoreboard and the top.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;
  localparam int ZERO_IDX  = 0;
  localparam bit ZERO_R0_DEF = 1'b1;

  // Clear-engine states.
  typedef enum logic [1:0] {IDLE, CLR, DONE} clr_state_t;

  // Index width for a register count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Bundles the read, write, pending and clear signals of the register file.
// Purely structural: no latency of its own.
// No backpressure: every request is taken in the cycle it is presented.
interface regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  import regfile_pkg::*;

  localparam int IDX_W = idx_w(NREGS);

  logic [NRD*IDX_W-1:0] rd_idx;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_pend;
  logic [NWR-1:0]       wr_en;
  logic [NWR*IDX_W-1:0] wr_idx;
  logic [NWR*XLEN-1:0]  wr_data;
  logic                 pend_set;
  logic [IDX_W-1:0]     pend_idx;
  logic                 clr_req;
  logic                 clr_busy;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_data, pend_set, pend_idx, clr_req,
    input  rd_data, rd_pend, clr_busy
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_data, pend_set, pend_idx, clr_req,
    output rd_data, rd_pend, clr_busy
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for long-latency writebacks.
// Set/clear land on the rising edge; rd_pend is combinational from the stored bits.
// No backpressure: a set or clear is always accepted.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter int IDX_W   = idx_w(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREGS-1:0]     wr_hit,
  input  logic                 pend_set,
  input  logic [IDX_W-1:0]     pend_idx,
  input  logic                 clr_act,
  input  logic [IDX_W-1:0]     clr_idx,
  input  logic [NRD*IDX_W-1:0] rd_idx,
  output logic [NRD-1:0]       rd_pend
);

  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_nxt;
  logic [IDX_W-1:0] ridx;

  // Writes and the clear engine drop bits; a new issue is younger so it is applied last.
  always_comb begin
    pend_nxt = pend & ~wr_hit;
    if (clr_act) pend_nxt[clr_idx] = 1'b0;
    if (pend_set && !(ZERO_R0 && pend_idx == IDX_W'(ZERO_IDX))) pend_nxt[pend_idx] = 1'b1;
  end

  // Pending bit storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend <= '0;
    else      pend <= pend_nxt;
  end

  // A writeback arriving this cycle already satisfies the reader.
  always_comb begin
    rd_pend = '0;
    ridx    = '0;
    for (int p = 0; p < NRD; p++) begin
      ridx       = rd_idx[p*IDX_W +: IDX_W];
      rd_pend[p] = pend[ridx] & ~wr_hit[ridx];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a sequential clear engine.
// Reads are combinational (0 cycles); writes land on the next rising edge; clear takes NREGS+1 cycles.
// No backpressure: clr_req while clr_busy is dropped, all other requests are always taken.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);

  localparam int IDX_W = idx_w(NREGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  logic [XLEN-1:0]  regs [NREGS];
  clr_state_t       state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             clr_act;
  logic [NWR-1:0]   wr_ok;
  logic [NREGS-1:0] wr_hit;
  logic [IDX_W-1:0] ridx;
  logic [XLEN-1:0]  rval;

  // Qualify write ports (r0 writes vanish) and flag every register written this cycle.
  always_comb begin
    wr_ok  = '0;
    wr_hit = '0;
    for (int w = 0; w < NWR; w++) begin
      wr_ok[w] = bus.wr_en[w] &&
                 !(ZERO_R0 && bus.wr_idx[w*IDX_W +: IDX_W] == IDX_W'(ZERO_IDX));
      if (wr_ok[w]) wr_hit[bus.wr_idx[w*IDX_W +: IDX_W]] = 1'b1;
    end
  end

  // Clear engine state and counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear engine: walk every index once, then one DONE cycle before going idle.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    clr_act      = 1'b0;
    bus.clr_busy = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = CLR;
          cnt_nxt   = '0;
        end
      end
      CLR: begin
        clr_act      = 1'b1;
        bus.clr_busy = 1'b1;
        if (cnt == LAST_IDX) state_nxt = DONE;
        else                 cnt_nxt   = cnt + IDX_W'(1);
      end
      DONE: begin
        bus.clr_busy = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage: higher-numbered ports are applied later and win; the clear overrides any port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w]) regs[bus.wr_idx[w*IDX_W +: IDX_W]] <= bus.wr_data[w*XLEN +: XLEN];
      end
      if (clr_act) regs[cnt] <= '0;
    end
  end

  // Read ports: stored value, overridden by the highest matching write port this cycle.
  always_comb begin
    bus.rd_data = '0;
    ridx        = '0;
    rval        = '0;
    for (int p = 0; p < NRD; p++) begin
      ridx = bus.rd_idx[p*IDX_W +: IDX_W];
      rval = regs[ridx];
      for (int w = 0; w < NWR; w++) begin
        if (wr_ok[w] && bus.wr_idx[w*IDX_W +: IDX_W] == ridx) rval = bus.wr_data[w*XLEN +: XLEN];
      end
      if (ZERO_R0 && ridx == IDX_W'(ZERO_IDX)) rval = '0;
      if (!rst) rval = '0;
      bus.rd_data[p*XLEN +: XLEN] = rval;
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NRD     (NRD),
    .ZERO_R0 (ZERO_R0),
    .IDX_W   (IDX_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_hit   (wr_hit),
    .pend_set (bus.pend_set),
    .pend_idx (bus.pend_idx),
    .clr_act  (clr_act),
    .clr_idx  (cnt),
    .rd_idx   (bus.rd_idx),
    .rd_pend  (bus.rd_pend)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for the multi-port register file.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// Every expected value below is hand-computed.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   busy_cnt;

  always #5 clk = ~clk;

  regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_R0(1'b1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.rd_idx   = '0;
    bus.wr_en    = '0;
    bus.wr_idx   = '0;
    bus.wr_data  = '0;
    bus.pend_set = 1'b0;
    bus.pend_idx = '0;
    bus.clr_req  = 1'b0;
  endtask

  task automatic set_rd(input int p, input int idx);
    bus.rd_idx[p*IDX_W +: IDX_W] = IDX_W'(idx);
  endtask

  task automatic set_wr(input int w, input int idx, input logic [31:0] d);
    bus.wr_en[w]                 = 1'b1;
    bus.wr_idx[w*IDX_W +: IDX_W] = IDX_W'(idx);
    bus.wr_data[w*XLEN +: XLEN]  = d;
  endtask

  function automatic logic [31:0] rdat(input int p);
    return bus.rd_data[p*XLEN +: XLEN];
  endfunction

  initial begin
    drive_idle();
    bus.wr_en = 2'b11;  // write enables during reset must not leak into reads
    bus.wr_idx = {5'd9, 5'd4};
    bus.wr_data = {32'h1111_1111, 32'h2222_2222};
    repeat (3) @(negedge clk);

    // 1: reset state on both ports
    for (int i = 0; i < NREGS; i++) begin
      set_rd(0, i);
      set_rd(1, NREGS - 1 - i);
      #1;
      check($sformatf("rst_rd0_%0d", i), rdat(0), 32'h0);
      check($sformatf("rst_rd1_%0d", i), rdat(1), 32'h0);
      check($sformatf("rst_pend_%0d", i), 32'(bus.rd_pend), 32'h0);
    end
    check("rst_busy", 32'(bus.clr_busy), 32'h0);
    @(negedge clk); drive_idle(); rst = 1'b1;
    set_rd(0, 4); set_rd(1, 9); #1;
    check("post_rst_rd0", rdat(0), 32'h0);
    check("post_rst_rd1", rdat(1), 32'h0);

    // 2: bypass then stored value
    @(negedge clk); drive_idle(); set_wr(0, 5, 32'hDEADBEEF); set_rd(0, 5); #1;
    check("byp_idx5", rdat(0), 32'hDEADBEEF);
    @(negedge clk); drive_idle(); set_rd(0, 5); set_rd(1, 5); #1;
    check("store_idx5_p0", rdat(0), 32'hDEADBEEF);
    check("store_idx5_p1", rdat(1), 32'hDEADBEEF);

    // 3: write port priority and r0
    @(negedge clk); drive_idle(); set_wr(0, 7, 32'h1); set_wr(1, 7, 32'h2);
    set_rd(0, 7); set_rd(1, 7); #1;
    check("prio_byp_p0", rdat(0), 32'h2);
    check("prio_byp_p1", rdat(1), 32'h2);
    @(negedge clk); drive_idle(); set_rd(0, 7); #1;
    check("prio_store", rdat(0), 32'h2);
    @(negedge clk); drive_idle(); set_wr(1, 0, 32'hFFFF); set_rd(0, 0); #1;
    check("r0_byp", rdat(0), 32'h0);
    @(negedge clk); drive_idle(); set_wr(0, 9, 32'h99); set_wr(1, 10, 32'hAA); set_rd(0, 0); #1;
    check("r0_store", rdat(0), 32'h0);
    @(negedge clk); drive_idle(); set_rd(0, 9); set_rd(1, 10); #1;
    check("dual_wr_9", rdat(0), 32'h99);
    check("dual_wr_10", rdat(1), 32'hAA);

    // 4: pending scoreboard
    @(negedge clk); drive_idle(); bus.pend_set = 1'b1; bus.pend_idx = 5'd3; set_rd(1, 3); #1;
    check("pend_not_yet", 32'(bus.rd_pend[1]), 32'h0);
    @(negedge clk); drive_idle(); set_rd(1, 3); #1;
    check("pend_set", 32'(bus.rd_pend[1]), 32'h1);
    @(negedge clk); drive_idle(); set_wr(0, 3, 32'h33); set_rd(1, 3); #1;
    check("pend_wr_same_cyc", 32'(bus.rd_pend[1]), 32'h0);
    check("pend_wr_data", rdat(1), 32'h33);
    @(negedge clk); drive_idle(); set_rd(1, 3); #1;
    check("pend_cleared", 32'(bus.rd_pend[1]), 32'h0);
    @(negedge clk); drive_idle(); bus.pend_set = 1'b1; bus.pend_idx = 5'd3;
    set_wr(1, 3, 32'h34); set_rd(0, 3); #1;
    check("pend_set_wr_cyc", 32'(bus.rd_pend[0]), 32'h0);
    @(negedge clk); drive_idle(); set_rd(0, 3); #1;
    check("pend_set_wins", 32'(bus.rd_pend[0]), 32'h1);
    check("pend_set_wr_data", rdat(0), 32'h34);
    @(negedge clk); drive_idle(); bus.pend_set = 1'b1; bus.pend_idx = 5'd0;
    @(negedge clk); drive_idle(); set_rd(0, 0); #1;
    check("pend_r0", 32'(bus.rd_pend[0]), 32'h0);

    // 5: fill with idx+1, then sequential clear
    for (int i = 0; i < NREGS / 2; i++) begin
      @(negedge clk); drive_idle();
      set_wr(0, 2 * i, 32'(2 * i + 1));
      set_wr(1, 2 * i + 1, 32'(2 * i + 2));
    end
    @(negedge clk); drive_idle(); set_rd(0, 31); set_rd(1, 17); #1;
    check("fill_31", rdat(0), 32'd32);
    check("fill_17", rdat(1), 32'd18);
    @(negedge clk); drive_idle(); bus.clr_req = 1'b1;
    busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk); drive_idle();
      if (k == 26) set_wr(0, 20, 32'hABCD);                      // cnt=25: idx 20 already cleared
      if (k == 27) set_wr(1, 26, 32'h55);                        // cnt=26: clear beats the write
      if (k == 28) begin bus.pend_set = 1'b1; bus.pend_idx = 5'd27; end  // cnt=27: set beats clear
      if (k == 30) bus.clr_req = 1'b1;                           // ignored while busy
      #1;
      if (bus.clr_busy) busy_cnt++;
      else break;
    end
    check("clr_busy_cycles", 32'(busy_cnt), 32'd33);
    @(negedge clk); drive_idle();
    for (int i = 0; i < NREGS; i++) begin
      set_rd(0, i); set_rd(1, i); #1;
      check($sformatf("clr_rd_%0d", i), rdat(0), (i == 20) ? 32'hABCD : 32'h0);
      check($sformatf("clr_pend_%0d", i), 32'(bus.rd_pend[1]), (i == 27) ? 32'h1 : 32'h0);
    end

    // 6: reset in the middle of a clear
    @(negedge clk); drive_idle(); set_wr(0, 30, 32'h77); bus.pend_set = 1'b1; bus.pend_idx = 5'd12;
    @(negedge clk); drive_idle(); bus.clr_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); drive_idle();
    end
    #1;
    check("mid_clr_busy", 32'(bus.clr_busy), 32'h1);
    @(negedge clk); rst = 1'b0; #1;  // cnt=10 at this point
    check("abort_busy", 32'(bus.clr_busy), 32'h0);
    for (int i = 0; i < NREGS; i++) begin
      set_rd(0, i); set_rd(1, i); #1;
      check($sformatf("abort_rd_%0d", i), rdat(0), 32'h0);
      check($sformatf("abort_pend_%0d", i), 32'(bus.rd_pend[1]), 32'h0);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check("post_abort_busy", 32'(bus.clr_busy), 32'h0);
    set_rd(0, 30); set_rd(1, 12); #1;
    check("post_abort_rd30", rdat(0), 32'h0);
    check("post_abort_pend12", 32'(bus.rd_pend[1]), 32'h0);
    @(negedge clk); bus.clr_req = 1'b1;
    @(negedge clk); drive_idle(); #1;
    check("reclr_busy", 32'(bus.clr_busy), 32'h1);
    busy_cnt = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (bus.clr_busy) busy_cnt++;
      else break;
    end
    check("reclr_busy_cycles", 32'(busy_cnt), 32'd33);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
